fpga_led_switch: RTL and testbench

Board-level I/O block that drives 16 LEDs from 16 slide switches. Four push-buttons each blank one 4-bit LED group. Switch and button inputs are asynchronous board signals. The block synchronizes them, debounces the buttons and registers the LED outputs, so the top level can wire it directly between the FPGA pins and the LED pins.

---
 rtl/fpga_led_switch.sv | 79 +++++++
 tb/tb_fpga_led_switch.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fpga_led_switch.sv
// Switch-to-LED board I/O block: synchronizes switches and buttons, debounces
// the buttons, and drives registered LEDs with per-group button blanking.
module fpga_led_switch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic [3:0]  btn,
  output logic [15:0] led
);

  // A zero-cycle debounce still needs a legal (unused) counter width.
  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [SYNC_STAGES-1:0][15:0] sw_chain;
  logic [SYNC_STAGES-1:0][3:0]  btn_chain;
  logic [15:0] sw_s;
  logic [3:0]  btn_s;
  logic [3:0]  btn_f;
  logic [15:0] led_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_chain  <= '0;
      btn_chain <= '0;
    end else begin
      sw_chain  <= {sw_chain[SYNC_STAGES-2:0], sw};
      btn_chain <= {btn_chain[SYNC_STAGES-2:0], btn};
    end
  end

  assign sw_s  = sw_chain[SYNC_STAGES-1];
  assign btn_s = btn_chain[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      assign btn_f = btn_s;
    end else begin : g_debounce
      for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic [CW-1:0] cnt;
        logic          filt;

        // Accept the new level only on the last of a run of mismatching edges.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            cnt  <= '0;
            filt <= 1'b0;
          end else if (btn_s[gi] == filt) begin
            cnt <= '0;
          end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            filt <= btn_s[gi];
            cnt  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        assign btn_f[gi] = filt;
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_group
      assign led_next[4*gi +: 4] = btn_f[gi] ? 4'h0 : sw_s[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_fpga_led_switch.sv
// Randomized and directed bench for fpga_led_switch with a queue-based
// scoreboard fed by a cycle-level behavioural model of the LED path.
module tb_fpga_led_switch;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic [3:0]  btn;
  logic [15:0] led;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  fpga_led_switch #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw),
    .btn(btn),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: inputs seen at edge e reach the synchronizer outputs SYNC-1 edges
  // later; a button level is accepted once it has disagreed with the filtered
  // value for DEB consecutive edges; the LED register shows the previous
  // cycle's synchronized switches with the previous filtered blanking.
  initial begin : model
    logic [19:0] in_q[$];
    logic [3:0]  bs_hist[$];
    logic [19:0] tap;
    logic [15:0] sws;
    logic [15:0] e;
    logic [3:0]  bs;
    logic [3:0]  bf;
    logic [3:0]  blank;
    bit          all_diff;
    sws = '0; bs = '0; bf = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        in_q.delete();
        bs_hist.delete();
        exp_q.delete();
        for (int i = 0; i < SYNC; i++) in_q.push_back('0);
        for (int i = 0; i < DEB; i++) bs_hist.push_back('0);
        sws = '0; bs = '0; bf = '0;
      end else begin
        blank = (DEB == 0) ? bs : bf;
        for (int g = 0; g < 4; g++) e[4*g +: 4] = blank[g] ? 4'h0 : sws[4*g +: 4];
        exp_q.push_back(e);
        if (DEB > 0) begin
          for (int g = 0; g < 4; g++) begin
            all_diff = 1'b1;
            foreach (bs_hist[k]) if (bs_hist[k][g] == bf[g]) all_diff = 1'b0;
            if (all_diff) bf[g] = ~bf[g];
          end
        end
        in_q.push_back({sw, btn});
        if (in_q.size() > SYNC) void'(in_q.pop_front());
        tap = in_q[0];
        sws = tap[19:4];
        bs  = tap[3:0];
        bs_hist.push_back(bs);
        if (bs_hist.size() > DEB) void'(bs_hist.pop_front());
      end
    end
  end

  initial begin : monitor
    logic [15:0] want;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checks++;
        if (led !== want) begin
          failures++;
          $display("FAIL led_cycle t=%0t sw=%h btn=%b led=%h expected=%h",
                   $time, sw, btn, led, want);
        end
      end
    end
  end

  task automatic hold(input logic [15:0] s, input logic [3:0] b, input int n);
    sw  = s;
    btn = b;
    $display("STEP sw=%h btn=%b cycles=%0d", s, b, n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (led !== 16'h0000) begin
      failures++;
      $display("FAIL %s led=%h expected=0000", name, led);
    end else begin
      $display("CHECK %s led=%h", name, led);
    end
  endtask

  typedef struct {
    logic [15:0] s;
    logic [3:0]  b;
  } step_t;

  step_t steps[12];

  initial begin : stim
    steps[0]  = '{16'hFFFF, 4'b0001};
    steps[1]  = '{16'hFFFF, 4'b0010};
    steps[2]  = '{16'hFFFF, 4'b0100};
    steps[3]  = '{16'hFFFF, 4'b1000};
    steps[4]  = '{16'hFFFF, 4'b0101};
    steps[5]  = '{16'hFFFF, 4'b1101};
    steps[6]  = '{16'hFFFF, 4'b1111};
    steps[7]  = '{16'hA5A5, 4'b0000};
    steps[8]  = '{16'h0F0F, 4'b0010};
    steps[9]  = '{16'hC3C3, 4'b0010};
    steps[10] = '{16'hF0F0, 4'b0010};
    steps[11] = '{16'hAAAA, 4'b1010};

    rst = 1'b1;
    sw  = 16'hFFFF;
    btn = 4'b1111;
    repeat (3) @(negedge clk);
    check_zero("reset_hold");

    btn = 4'b0000;
    rst = 1'b0;
    hold(16'hFFFF, 4'b0000, 12);

    foreach (steps[i]) hold(steps[i].s, steps[i].b, 12);

    hold(16'hFFFF, 4'b0000, 12);
    hold(16'hFFFF, 4'b0001, 3);
    hold(16'hFFFF, 4'b0000, 12);
    hold(16'hFFFF, 4'b0001, 12);
    hold(16'hFFFF, 4'b0000, 12);

    // Reset in the middle of a debounce, away from any clock edge.
    hold(16'hFFFF, 4'b0101, 12);
    hold(16'hFFFF, 4'b0111, 3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("reset_async");
    @(negedge clk);
    rst = 1'b0;
    hold(16'hFFFF, 4'b0101, 12);

    // Simultaneous switch and button change.
    hold(16'h1234, 4'b0001, 12);

    for (int i = 0; i < 80; i++) begin
      hold(16'($urandom), 4'($urandom), int'($urandom_range(1, 9)));
    end
    hold(16'h5A5A, 4'b0000, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
